psg_bus_arbiter: RTL and testbench
==================================

PSG_BUS_ARBITER -- requirements
Module: psg_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_CACHE, default 1; when 1, skip the address-latch phase if the target register is already latched in the PSG.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ce, input, 1 bit: PSG clock enable, shared with the PSG; the FSM advances only on edges where ce=1.
REQ-005 SHALL have ports req0 and req1, input, 1 bit each: requester 0/1 transaction request, level-held until ack.
REQ-006 SHALL have ports we0 and we1, input, 1 bit each: 1=write, 0=read.
REQ-007 SHALL have ports addr0 and addr1, input, 4 bits each: PSG register number R0..R15.
REQ-008 SHALL have ports wdata0 and wdata1, input, 8 bits each: write data.
REQ-009 SHALL have ports ack0 and ack1, output, 1 bit each: one-clock completion pulse.
REQ-010 SHALL have port rdata, output, 8 bits: read result, valid from the ack clock until the next read completes.
REQ-011 SHALL have ports psg_bdir and psg_bc1, output, 1 bit each: registered PSG bus control (bc2 is tied to 1 externally).
REQ-012 SHALL have port psg_d, output, 8 bits: registered PSG data/address bus.
REQ-013 SHALL have port psg_q, input, 8 bits: PSG read data.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, LATCH, ACCESS and DONE; every transition SHALL require ce=1.
REQ-016 IDLE, any req: SHALL grant one requester and capture its we, addr and wdata internally; go to ACCESS if ADDR_CACHE=1, cache_valid=1 and cache_addr equals the captured addr, else go to LATCH.
REQ-017 Arbitration SHALL be round-robin on last_grant: if exactly one req is high, grant it; if both are high, grant the port other than last_grant. The grant SHALL update last_grant.
REQ-018 LATCH: SHALL drive bdir=1, bc1=1, psg_d={4'b0000,addr}; on exit set cache_addr=addr and cache_valid=1, then go to ACCESS.
REQ-019 ACCESS, write: SHALL drive bdir=1, bc1=0, psg_d=wdata.
REQ-020 ACCESS, read: SHALL drive bdir=0, bc1=1, psg_d=0, and capture psg_q into rdata on the exiting edge.
REQ-021 SHALL go from ACCESS to DONE.
REQ-022 Entering DONE: SHALL pulse the granted port's ack for exactly one clock, regardless of ce.
REQ-023 DONE: SHALL drive bdir=0, bc1=0, psg_d=0 and go to IDLE; the requester SHALL drop req within that window.
REQ-024 IDLE and DONE: SHALL drive bdir=0, bc1=0, psg_d=0.
REQ-025 SHALL register bus outputs so they change only on clock edges where the state changes; the PSG samples them at the next ce edge.
REQ-026 Latency with ce held 1: req high before edge N gives LATCH in cycle N, ACCESS in N+1, ack in N+2, IDLE in N+3, next grant at edge N+4; a cache hit is one cycle shorter.
REQ-027 A req change while a transaction is in flight SHALL be ignored until IDLE.
REQ-028 The non-granted port SHALL keep its req and be served next.
REQ-029 ce=0 SHALL freeze the state and bus outputs; ack SHALL not be asserted until DONE is entered.
REQ-030 Reads of R14/R15 SHALL follow the same sequence; no special case.

Reset
REQ-031 reset=1 SHALL force, at the next edge: state=IDLE, psg_bdir=0, psg_bc1=0, psg_d=0, ack0=ack1=0, rdata=0, busy=0, cache_valid=0, last_grant=1 (so port 0 wins the first tie).
REQ-032 Reset mid-transaction SHALL abort it with no ack.
REQ-033 After a mid-transaction reset, the next transaction SHALL use LATCH.
REQ-034 Reset SHALL have priority over ce.

Verification
REQ-035 ce=1; req0 writes R7=0x38 -> bus reads (1,1,0x07), then (1,0,0x38), then ack0 one clock at N+2, then bus idle.
REQ-036 ADDR_CACHE=1; two consecutive port-0 writes to R8 (0x0F, then 0x10) -> second has no LATCH phase, ack one cycle sooner.
REQ-037 req0 and req1 both held after reset -> order is 0,1,0,1; each ack aligns with its own port.
REQ-038 Read R14 with psg_q=0xA5 -> rdata=0xA5 at ack0; rdata holds through a subsequent write.
REQ-039 ce pulsed every 8th clock -> each phase lasts 8 clocks, ack still exactly one clock.
REQ-040 reset asserted during ACCESS -> no ack, bus at 0 next edge; a following write to the same register starts with LATCH.

Source files
------------

// File: rtl/psg_bus_arbiter.sv
// Two-port arbiter for the PSG register bus (BDIR/BC1 protocol, BC2 tied high).
// Round-robin grant, optional latched-address cache, registered bus outputs.
module psg_bus_arbiter #(
  parameter int ADDR_CACHE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       psg_bdir,
  output logic       psg_bc1,
  output logic [7:0] psg_d,
  input  logic [7:0] psg_q,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    ACCESS,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       grant_q, grant_d;
  logic       we_q, we_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       cache_valid_q, cache_valid_d;
  logic [3:0] cache_addr_q, cache_addr_d;
  logic [7:0] rdata_q, rdata_d;
  logic       bdir_q, bdir_d;
  logic       bc1_q, bc1_d;
  logic [7:0] pd_q, pd_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;

  logic       sel;
  logic       sel_we;
  logic [3:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       hit;
  logic       enter_done;

  // Tie goes to the port that was not served last.
  always_comb begin
    sel       = (req0 & req1) ? ~last_grant_q : req1;
    sel_we    = sel ? we1 : we0;
    sel_addr  = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    hit       = (ADDR_CACHE != 0) && cache_valid_q &&
                (cache_addr_q == sel_addr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= 4'h0;
      wdata_q       <= 8'h00;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= 4'h0;
      rdata_q       <= 8'h00;
      bdir_q        <= 1'b0;
      bc1_q         <= 1'b0;
      pd_q          <= 8'h00;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      rdata_q       <= rdata_d;
      bdir_q        <= bdir_d;
      bc1_q         <= bc1_d;
      pd_q          <= pd_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    rdata_d       = rdata_q;
    if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            grant_d      = sel;
            last_grant_d = sel;
            we_d         = sel_we;
            addr_d       = sel_addr;
            wdata_d      = sel_wdata;
            state_d      = hit ? ACCESS : LATCH;
          end
        end
        LATCH: begin
          cache_addr_d  = addr_q;
          cache_valid_d = 1'b1;
          state_d       = ACCESS;
        end
        ACCESS: begin
          if (!we_q) rdata_d = psg_q;
          state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus values are derived from the next state so they land with it.
  always_comb begin
    bdir_d     = 1'b0;
    bc1_d      = 1'b0;
    pd_d       = 8'h00;
    enter_done = (state_d == DONE) && (state_q != DONE);
    unique case (1'b1)
      state_d == LATCH: begin
        bdir_d = 1'b1;
        bc1_d  = 1'b1;
        pd_d   = {4'b0000, addr_d};
      end
      state_d == ACCESS && we_d: begin
        bdir_d = 1'b1;
        pd_d   = wdata_d;
      end
      state_d == ACCESS && !we_d: begin
        bc1_d = 1'b1;
      end
      default: begin
        bdir_d = 1'b0;
      end
    endcase
    ack0_d = enter_done & ~grant_q;
    ack1_d = enter_done & grant_q;
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign psg_bdir = bdir_q;
  assign psg_bc1  = bc1_q;
  assign psg_d    = pd_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_psg_bus_arbiter.sv
// Directed bench for psg_bus_arbiter.
// Bus is checked as {bdir, bc1, d} one step after each rising edge.
module tb_psg_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = 4'h0, addr1 = 4'h0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic       psg_bdir, psg_bc1;
  logic [7:0] psg_d;
  logic [7:0] psg_q = 8'h00;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit ce_div = 1'b0;

  psg_bus_arbiter #(.ADDR_CACHE(1)) dut (
    .clock(clock), .reset(reset), .ce(ce),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .psg_bdir(psg_bdir), .psg_bc1(psg_bc1),
    .psg_d(psg_d), .psg_q(psg_q), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (ce_div) ce = (cyc % 8 == 0);
  endtask

  function automatic logic [31:0] bus();
    return {22'd0, psg_bdir, psg_bc1, psg_d};
  endfunction

  initial begin
    int seq[$];
    int nl, na, nk;
    bit started, done;

    // Reset state
    reset = 1'b1;
    tick();
    check("rst_bus", bus(), 32'h000);
    check("rst_ack", {ack0, ack1}, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Write R7 = 0x38 from port 0, cache miss
    req0 = 1; we0 = 1; addr0 = 4'd7; wdata0 = 8'h38;
    tick();
    check("w7_latch", bus(), 32'h307);
    check("w7_busy", busy, 1);
    check("w7_noack", ack0, 0);
    tick();
    check("w7_access", bus(), 32'h238);
    tick();
    check("w7_ack0", {ack0, ack1}, 2'b10);
    check("w7_done", bus(), 32'h000);
    req0 = 0;
    tick();
    check("w7_ackoff", ack0, 0);
    check("w7_idle", busy, 0);

    // Two writes to R8: second hits the address cache
    req0 = 1; addr0 = 4'd8; wdata0 = 8'h0F;
    tick();
    check("w8a_latch", bus(), 32'h308);
    tick();
    check("w8a_access", bus(), 32'h20F);
    tick();
    check("w8a_ack", ack0, 1);
    req0 = 0;
    tick();
    req0 = 1; wdata0 = 8'h10;
    tick();
    check("w8b_access", bus(), 32'h210);
    tick();
    check("w8b_ack", ack0, 1);
    req0 = 0;
    tick();
    check("w8b_idle", busy, 0);

    // Read R14, then a cached write to R14 keeps rdata
    req0 = 1; we0 = 0; addr0 = 4'd14; psg_q = 8'hA5;
    tick();
    check("r14_latch", bus(), 32'h30E);
    tick();
    check("r14_access", bus(), 32'h100);
    tick();
    check("r14_ack", ack0, 1);
    check("r14_rdata", rdata, 8'hA5);
    req0 = 0; psg_q = 8'h00;
    tick();
    req0 = 1; we0 = 1; wdata0 = 8'h55;
    tick();
    check("w14_access", bus(), 32'h255);
    tick();
    check("w14_ack", ack0, 1);
    check("w14_rdata_hold", rdata, 8'hA5);
    req0 = 0;
    tick();

    // Both ports held after reset: 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1; we0 = 1; addr0 = 4'd2; wdata0 = 8'h22;
    req1 = 1; we1 = 1; addr1 = 4'd3; wdata1 = 8'h33;
    tick();
    check("rr_first_latch", bus(), 32'h302);
    for (int i = 0; i < 40 && seq.size() < 4; i++) begin
      tick();
      if (ack0 && ack1) check("rr_both_ack", 1, 0);
      if (ack0) seq.push_back(0);
      if (ack1) seq.push_back(1);
    end
    req0 = 0; req1 = 0;
    check("rr_count", seq.size(), 4);
    for (int k = 0; k < seq.size(); k++)
      check($sformatf("rr_order%0d", k), seq[k], k % 2);
    tick();
    check("rr_idle", busy, 0);

    // ce every 8th clock: 8-clock phases, 1-clock ack
    ce_div = 1; ce = 0;
    req1 = 1; we1 = 1; addr1 = 4'd5; wdata1 = 8'h5A;
    nl = 0; na = 0; nk = 0; started = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (bus() == 32'h305) nl++;
      if (bus() == 32'h25A) na++;
      if (ack1) begin
        nk++;
        req1 = 0;
      end
      if (busy) started = 1;
      else if (started) done = 1;
    end
    check("ce_done", done, 1);
    check("ce_latch_len", nl, 8);
    check("ce_access_len", na, 8);
    check("ce_ack_len", nk, 1);
    ce_div = 0; ce = 1;

    // Reset during ACCESS aborts; retry relatches
    req0 = 1; we0 = 1; addr0 = 4'd9; wdata0 = 8'h99;
    tick();
    check("ab_latch", bus(), 32'h309);
    tick();
    check("ab_access", bus(), 32'h299);
    reset = 1'b1;
    tick();
    check("ab_bus0", bus(), 32'h000);
    check("ab_noack", {ack0, ack1}, 0);
    check("ab_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("ab_relatch", bus(), 32'h309);
    tick();
    check("ab_reaccess", bus(), 32'h299);
    tick();
    check("ab_ack", ack0, 1);
    req0 = 0;
    tick();
    check("ab_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
